// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl : 8-digit common-anode 7-segment scan controller with
//                 double-buffered BCD digits, leading-zero blanking and DP.
// Revision      : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  dp_en,
  input  logic        lz_en,
  output logic [7:0]  Cout,
  output logic [7:0]  Dout,
  output logic        frame_done
);

  localparam int              CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      pend_data_q, pend_data_d;
  logic [7:0]       pend_dp_q, pend_dp_d;
  logic             pend_lz_q, pend_lz_d;
  logic [31:0]      act_data_q, act_data_d;
  logic [7:0]       act_dp_q, act_dp_d;
  logic             act_lz_q, act_lz_d;
  logic [7:0]       cout_q, cout_d;
  logic [7:0]       dout_q, dout_d;
  logic             frame_done_q, frame_done_d;

  logic             frame_wrap;
  logic             lz_blank;
  logic [3:0]       cur_nib;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign frame_wrap = enable && (state_q == ST_SHOW) && (idx_q == 3'd7) && (cnt_q == CNT_LAST);
  assign cur_nib    = 4'(act_data_q >> {idx_q, 2'b00});
  // Digit k is a leading zero when every nibble from k upward is zero.
  assign lz_blank   = act_lz_q && (idx_q != 3'd0) && ((act_data_q >> {idx_q, 2'b00}) == 32'd0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_lz_d    = pend_lz_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_lz_d     = act_lz_q;
    cout_d       = 8'hFF;
    dout_d       = 8'hFF;
    frame_done_d = frame_wrap;

    if (load) begin
      pend_data_d = data;
      pend_dp_d   = dp_en;
      pend_lz_d   = lz_en;
    end

    // Active digits only change between frames, bypassing pending on a same-cycle load.
    if ((state_q == ST_IDLE) || frame_wrap) begin
      act_data_d = load ? data  : pend_data_q;
      act_dp_d   = load ? dp_en : pend_dp_q;
      act_lz_d   = load ? lz_en : pend_lz_q;
    end

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end
        ST_BLANK, ST_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          state_d = (cnt_d < BLANK_END) ? ST_BLANK : ST_SHOW;
          if (state_q == ST_SHOW) begin
            cout_d = ~(8'b1 << idx_q);
            dout_d = {~act_dp_q[idx_q], (lz_blank ? 7'h7F : seg7(cur_nib))};
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      pend_data_q  <= 32'd0;
      pend_dp_q    <= 8'd0;
      pend_lz_q    <= 1'b0;
      act_data_q   <= 32'd0;
      act_dp_q     <= 8'd0;
      act_lz_q     <= 1'b0;
      cout_q       <= 8'hFF;
      dout_q       <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_lz_q    <= pend_lz_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_lz_q     <= act_lz_d;
      cout_q       <= cout_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign Cout       = cout_q;
  assign Dout       = dout_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl : vector table + cycle scoreboard bench for seg_scan_ctrl.
// Revision         : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = 8 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data = 32'd0;
  logic [7:0]  dp_en = 8'd0;
  logic        lz_en = 1'b0;
  logic [7:0]  Cout;
  logic [7:0]  Dout;
  logic        frame_done;

  seg_scan_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .data       (data),
    .dp_en      (dp_en),
    .lz_en      (lz_en),
    .Cout       (Cout),
    .Dout       (Dout),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // seg[k] is the expected Dout while digit k is shown.
  typedef struct packed {
    logic [31:0]     data;
    logic [7:0]      dp;
    logic            lz;
    logic [7:0][7:0] seg;
  } vec_t;

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] d;
    logic       f;
  } exp_t;

  vec_t  tbl [6];
  exp_t  sbq [$];
  int    checks = 0;
  int    errors = 0;
  string tag = "init";

  // Expected-behaviour model: m_pre is the slot-cycle position before the next edge (-1 = idle).
  int m_pre  = -1;
  int act_v  = 5;
  int pend_v = 5;

  task automatic chk_now(input string name, input logic [16:0] got, input logic [16:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got Cout/Dout/fd=%h required %h", name, got, req);
    end
  endtask

  task automatic tick(input logic en, input logic ld, input int vi);
    exp_t e;
    exp_t got_e;
    logic wrap;
    int   k;
    int   old_pend;
    enable = en;
    load   = ld;
    data   = tbl[vi].data;
    dp_en  = tbl[vi].dp;
    lz_en  = tbl[vi].lz;
    wrap   = en && (m_pre >= 0) && ((m_pre % FRAME) == FRAME - 1);
    e.f    = wrap;
    if (!en || m_pre < 0 || (m_pre % SCAN_DIV) < BLANK_CYC) begin
      e.c = 8'hFF;
      e.d = 8'hFF;
    end else begin
      k   = (m_pre / SCAN_DIV) % 8;
      e.c = ~(8'b1 << k);
      e.d = tbl[act_v].seg[k];
    end
    old_pend = pend_v;
    if (ld) pend_v = vi;
    if (m_pre < 0 || wrap) act_v = ld ? vi : old_pend;
    m_pre = en ? ((m_pre + 1) % FRAME) : -1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got_e = sbq.pop_front();
    checks++;
    if ({Cout, Dout, frame_done} !== {got_e.c, got_e.d, got_e.f}) begin
      errors++;
      $display("FAIL %s (pos %0d): Cout=%h Dout=%h fd=%b, expected Cout=%h Dout=%h fd=%b",
               tag, m_pre, Cout, Dout, frame_done, got_e.c, got_e.d, got_e.f);
    end
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_pre == pos) break;
      tick(1'b1, 1'b0, 0);
    end
  endtask

  initial begin
    tbl[0] = '{32'h8765_4321, 8'h00, 1'b0, 64'h80F8_8292_99B0_A4F9};
    tbl[1] = '{32'h0000_0105, 8'h02, 1'b1, 64'hFFFF_FFFF_FFF9_4092};
    tbl[2] = '{32'h9876_0C10, 8'h00, 1'b0, 64'h9080_F882_C0FF_F9C0};
    tbl[3] = '{32'h0000_0000, 8'h81, 1'b1, 64'h7FFF_FFFF_FFFF_FF40};
    tbl[4] = '{32'hFEDC_BA98, 8'hFF, 1'b1, 64'h7F7F_7F7F_7F7F_1000};
    tbl[5] = '{32'h0000_0000, 8'h00, 1'b0, 64'hC0C0_C0C0_C0C0_C0C0};

    #12;
    chk_now("reset_state", {Cout, Dout, frame_done}, {8'hFF, 8'hFF, 1'b0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // One full frame per table vector, loaded while idle.
    for (int v = 0; v < 5; v++) begin
      $sformat(tag, "vector%0d", v);
      tick(1'b0, 1'b1, v);
      for (int i = 0; i < FRAME + 2; i++) tick(1'b1, 1'b0, 0);
      tick(1'b0, 1'b0, 0);
      tick(1'b0, 1'b0, 0);
    end

    tag = "midframe_load";
    tick(1'b0, 1'b1, 0);
    run_to(13);
    tick(1'b1, 1'b1, 2);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 0);

    tag = "wrap_load";
    run_to(FRAME - 1);
    tick(1'b1, 1'b1, 1);
    for (int i = 0; i < FRAME + 2; i++) tick(1'b1, 1'b0, 0);

    tag = "back_to_back_load";
    run_to(10);
    tick(1'b1, 1'b1, 3);
    tick(1'b1, 1'b1, 4);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 0);

    tag = "enable_drop";
    run_to(22);
    tick(1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 0);
    for (int i = 0; i < FRAME + 2; i++) tick(1'b1, 1'b0, 0);

    tag = "reset_midframe";
    run_to(18);
    tick(1'b1, 1'b1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_now("async_reset", {Cout, Dout, frame_done}, {8'hFF, 8'hFF, 1'b0});
    m_pre  = -1;
    act_v  = 5;
    pend_v = 5;
    @(posedge clk);
    #1;
    chk_now("reset_held", {Cout, Dout, frame_done}, {8'hFF, 8'hFF, 1'b0});
    rst_n = 1'b1;
    tag = "after_reset";
    for (int i = 0; i < FRAME + 2; i++) tick(1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
